scan_master: RTL and testbench

- Initiator side of the on-board boundary-scan chain; drives tdi, shift_dr, up_enable, mode, sel and bp_shift into a target device, and samples its tdo.
- Runs one of two sequences per command:
  - EXTEST: capture, shift, update through the boundary cells.
  - BYPASS: shift through the 1-bit bypass register.
- Provides start/busy/done to the test sequencer.
- Returns the shifted-out word as rx_data.

---
 rtl/scan_pkg.sv | 33 +++
 rtl/scan_shreg.sv | 75 +++++++
 rtl/scan_master.sv | 209 ++++++++++++++++++++
 tb/tb_scan_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg - shared definitions for the boundary-scan initiator.
//
// Contents:
//   scan_state_t : controller state encoding (3 bits)
//   OP_EXTEST    : command code for capture/shift/update through the boundary cells
//   OP_BYPASS    : command code for a shift through the 1-bit bypass register
//   clog2()      : ceiling log2, used to size counters and indices
//
// Optional feature macro used by the files importing this package: SCAN_CHECK_EN.

package scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } scan_state_t;

  localparam logic OP_EXTEST = 1'b0;
  localparam logic OP_BYPASS = 1'b1;

  // Smallest r with 2**r >= value; returns at least 1 so sized vectors never collapse.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// scan_shreg - paired transmit/receive shift registers for the scan initiator.
//
// The tx side is parallel-loaded with the command pattern and shifted left
// one place per shift cycle, so the MSB is always the next bit to present.
// The rx side is written one bit at a time at an explicit index, which lets
// the controller place each returned bit directly where it belongs.
//
// Ports:
//   tck          in   scan clock
//   rst          in   asynchronous active-high reset, clears both registers
//   load         in   parallel-load tx register from load_data
//   load_data    in   [CHAIN_LEN] pattern to load
//   shift        in   shift tx register left by one (zero fill)
//   sample       in   write sample_bit into rx register at sample_idx
//   sample_idx   in   [clog2(CHAIN_LEN)] rx bit index
//   sample_bit   in   serial bit returned from the target
//   tx_msb       out  current MSB of the tx register
//   tx_next      out  bit that becomes MSB after the next shift
//   rx_data      out  [CHAIN_LEN] received word
//
// No dependency on SCAN_CHECK_EN.

module scan_shreg
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 6
) (
  input  logic                          tck,
  input  logic                          rst,
  input  logic                          load,
  input  logic [CHAIN_LEN-1:0]          load_data,
  input  logic                          shift,
  input  logic                          sample,
  input  logic [clog2(CHAIN_LEN)-1:0]   sample_idx,
  input  logic                          sample_bit,
  output logic                          tx_msb,
  output logic                          tx_next,
  output logic [CHAIN_LEN-1:0]          rx_data
);

  logic [CHAIN_LEN-1:0] tx_q;
  logic [CHAIN_LEN-1:0] rx_d;

  // Transmit register: load wins over shift; zeros fill from the bottom so
  // the bit presented after the pattern is exhausted is always 0.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= load_data;
    end else if (shift) begin
      tx_q <= {tx_q[CHAIN_LEN-2:0], 1'b0};
    end
  end

  assign tx_msb  = tx_q[CHAIN_LEN-1];
  assign tx_next = tx_q[CHAIN_LEN-2];

  // Receive register next value: only the addressed bit changes.
  always_comb begin
    rx_d = rx_data;
    if (sample) begin
      rx_d[sample_idx] = sample_bit;
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
    end else begin
      rx_data <= rx_d;
    end
  end

endmodule

// File: rtl/scan_master.sv
// scan_master - initiator for the on-board boundary-scan chain.
//
// Runs one EXTEST (capture, shift, update) or BYPASS (shift through the
// 1-bit bypass register) sequence per accepted start, and returns the word
// shifted out of tdo on rx_data. Every control output is a flop whose value
// is computed from the next state, so it is valid for the whole cycle in
// which the state register holds the corresponding state.
//
// Ports:
//   tck        in   scan clock
//   rst        in   asynchronous active-high reset
//   start      in   command strobe, honoured only in IDLE
//   op         in   0 = EXTEST, 1 = BYPASS
//   mode_in    in   value for mode during this command
//   tx_data    in   [CHAIN_LEN] pattern to shift into the chain
//   busy       out  high in CAPTURE, SHIFT and UPDATE
//   done       out  one-cycle pulse in DONE
//   rx_data    out  [CHAIN_LEN] word shifted out of tdo
//   tdi        out  serial data to target
//   shift_dr   out  boundary chain shift enable
//   up_enable  out  update-latch strobe
//   mode       out  target test-mode select, held between commands
//   sel        out  target tdo mux (1 = bypass register)
//   bp_shift   out  bypass register shift enable
//   tdo        in   serial data from target
//   exp_data   in   [CHAIN_LEN] expected rx word (SCAN_CHECK_EN only)
//   mismatch   out  rx_data differs from exp_data (SCAN_CHECK_EN only)
//
// Optional feature macro: SCAN_CHECK_EN.

module scan_master
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 6
) (
  input  logic                 tck,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic                 mode_in,
  input  logic [CHAIN_LEN-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rx_data,
  output logic                 tdi,
  output logic                 shift_dr,
  output logic                 up_enable,
  output logic                 mode,
  output logic                 sel,
  output logic                 bp_shift,
  input  logic                 tdo
`ifdef SCAN_CHECK_EN
  ,
  input  logic [CHAIN_LEN-1:0] exp_data,
  output logic                 mismatch
`endif
);

  localparam int CW = clog2(CHAIN_LEN + 1);
  localparam int IW = clog2(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST_EX = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST_BP = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q;
  logic          op_eff;
  logic          accept;

  logic          busy_d, done_d, tdi_d, shift_dr_d, up_enable_d, mode_d, sel_d, bp_shift_d;

  logic          tx_shift, rx_sample;
  logic [CW-1:0] rx_idx_full;
  logic [IW-1:0] rx_idx;
  logic          tx_msb, tx_next;

  assign accept = (state_q == IDLE) && start;
  // While still in IDLE the latched op is stale, so decode from the live input.
  assign op_eff = (state_q == IDLE) ? op : op_q;

  // Next-state and shift counter. The counter runs only inside SHIFT and
  // holds at the bypass terminal count instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (op == OP_BYPASS) ? SHIFT : CAPTURE;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        if (op_q == OP_EXTEST) begin
          if (cnt_q == CNT_LAST_EX) state_d = UPDATE;
        end else begin
          if (cnt_q == CNT_LAST_BP) state_d = DONE;
        end
        if (state_d == SHIFT) begin
          cnt_d = (cnt_q == CNT_LAST_BP) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle. tdi for the first shift cycle comes
  // from the input (BYPASS enters SHIFT straight from IDLE) or from the freshly
  // loaded register (after CAPTURE); after that it is the bit below the MSB.
  always_comb begin
    busy_d      = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
    done_d      = (state_d == DONE);
    shift_dr_d  = (state_d == SHIFT) && (op_eff == OP_EXTEST);
    sel_d       = (state_d == SHIFT) && (op_eff == OP_BYPASS);
    bp_shift_d  = (state_d == SHIFT) && (op_eff == OP_BYPASS);
    up_enable_d = (state_d == UPDATE);
    mode_d      = accept ? mode_in : mode;
    tdi_d       = 1'b0;
    if (state_d == SHIFT) begin
      case (state_q)
        IDLE:    tdi_d = tx_data[CHAIN_LEN-1];
        CAPTURE: tdi_d = tx_msb;
        default: tdi_d = tx_next;
      endcase
    end
  end

  // Return path placement. EXTEST bit k lands at CHAIN_LEN-1-k; BYPASS is one
  // cycle behind because of the bypass flop, so cycle 0 carries nothing.
  always_comb begin
    tx_shift    = (state_q == SHIFT);
    rx_sample   = (state_q == SHIFT) && ((op_q == OP_EXTEST) || (cnt_q != '0));
    rx_idx_full = (op_q == OP_EXTEST) ? (CNT_LAST_EX - cnt_q) : (CNT_LAST_BP - cnt_q);
    rx_idx      = rx_idx_full[IW-1:0];
  end

  // State, counter, latched command and all registered control outputs.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_EXTEST;
      busy      <= 1'b0;
      done      <= 1'b0;
      tdi       <= 1'b0;
      shift_dr  <= 1'b0;
      up_enable <= 1'b0;
      mode      <= 1'b0;
      sel       <= 1'b0;
      bp_shift  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) op_q <= op;
      busy      <= busy_d;
      done      <= done_d;
      tdi       <= tdi_d;
      shift_dr  <= shift_dr_d;
      up_enable <= up_enable_d;
      mode      <= mode_d;
      sel       <= sel_d;
      bp_shift  <= bp_shift_d;
    end
  end

  scan_shreg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shreg (
    .tck        (tck),
    .rst        (rst),
    .load       (accept),
    .load_data  (tx_data),
    .shift      (tx_shift),
    .sample     (rx_sample),
    .sample_idx (rx_idx),
    .sample_bit (tdo),
    .tx_msb     (tx_msb),
    .tx_next    (tx_next),
    .rx_data    (rx_data)
  );

`ifdef SCAN_CHECK_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] rx_final;

  // The last BYPASS bit arrives on the same edge that enters DONE, so the
  // comparison uses the word including any sample taken on that edge.
  always_comb begin
    rx_final = rx_data;
    if (rx_sample) rx_final[rx_idx] = tdo;
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      exp_q    <= exp_data;
      mismatch <= 1'b0;
    end else if (state_d == DONE) begin
      mismatch <= (rx_final != exp_q);
    end
  end
`endif

endmodule

// File: tb/tb_scan_master.sv
// tb_scan_master - scoreboard bench for scan_master with a behavioural
// 6-cell boundary-scan target plus bypass register.
//
// Commands push their expected response into a queue; an independent monitor
// pops one entry on every done pulse and checks rx_data, done timing, control
// pulse counts, the target update latch and mode. Define SCAN_CHECK_EN to also
// exercise exp_data/mismatch.

module tb_scan_master;
  import scan_pkg::*;

  localparam int L = 6;

  logic         tck = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         mode_in = 1'b0;
  logic [L-1:0] tx_data = '0;
  logic         busy, done, tdi, shift_dr, up_enable, mode, sel, bp_shift, tdo;
  logic [L-1:0] rx_data;
`ifdef SCAN_CHECK_EN
  logic [L-1:0] exp_data = '0;
  logic         mismatch;
`endif

  scan_master #(.CHAIN_LEN(L)) dut (
    .tck       (tck),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .mode_in   (mode_in),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .tdi       (tdi),
    .shift_dr  (shift_dr),
    .up_enable (up_enable),
    .mode      (mode),
    .sel       (sel),
    .bp_shift  (bp_shift),
    .tdo       (tdo)
`ifdef SCAN_CHECK_EN
    ,
    .exp_data  (exp_data),
    .mismatch  (mismatch)
`endif
  );

  always #5 tck = ~tck;

  int cyc = 0;
  always @(posedge tck) cyc <= cyc + 1;

  // Behavioural target: cell 0 is nearest tdi, cells capture their parallel
  // inputs whenever neither shifting nor updating, update latch copies cells.
  logic [L-1:0] par_in    = 6'b010011;
  logic [L-1:0] cells     = '0;
  logic [L-1:0] upd_latch = '0;
  logic         bp_reg    = 1'b0;

  always @(posedge tck) begin
    if (shift_dr)        cells <= {cells[L-2:0], tdi};
    else if (!up_enable) cells <= par_in;
    if (up_enable)       upd_latch <= cells;
    if (bp_shift)        bp_reg <= tdi;
  end

  assign tdo = sel ? bp_reg : cells[L-1];

  typedef struct {
    logic [L-1:0] rx;
    int           done_cyc;
    int           n_shift;
    int           n_up;
    int           n_bp;
    bit           chk_upd;
    logic [L-1:0] upd;
    logic         mode;
    logic         mm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Drives one start strobe and records what the monitor should see at done.
  task automatic applyStimulus(input logic o, input logic m, input logic [L-1:0] tx,
                               input logic [L-1:0] rx_exp, input logic [L-1:0] upd_exp,
                               input logic [L-1:0] ex);
    exp_t e;
    @(negedge tck);
    start   = 1'b1;
    op      = o;
    mode_in = m;
    tx_data = tx;
`ifdef SCAN_CHECK_EN
    exp_data = ex;
`endif
    e.rx       = rx_exp;
    e.done_cyc = cyc + ((o == OP_BYPASS) ? (L + 2) : (L + 3));
    e.n_shift  = (o == OP_BYPASS) ? 0 : L;
    e.n_up     = (o == OP_BYPASS) ? 0 : 1;
    e.n_bp     = (o == OP_BYPASS) ? (L + 1) : 0;
    e.chk_upd  = (o == OP_EXTEST);
    e.upd      = upd_exp;
    e.mode     = m;
    e.mm       = (rx_exp != ex);
    sb.push_back(e);
    @(negedge tck);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    do begin
      @(negedge tck);
      n = n + 1;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s: got no done within 40 cycles, expected a done pulse", name);
    end
  endtask

  // Monitor: accumulates pulse counts and checks one scoreboard entry per done.
  initial begin
    exp_t e;
    int ns, nu, nb;
    ns = 0; nu = 0; nb = 0;
    forever begin
      @(negedge tck);
      if (rst) begin
        ns = 0; nu = 0; nb = 0;
      end else begin
        ns = ns + int'(shift_dr);
        nu = nu + int'(up_enable);
        nb = nb + int'(sel && bp_shift);
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("rx_data", 32'(rx_data), 32'(e.rx));
            checkOutput("done_cycle", cyc, e.done_cyc);
            checkOutput("shift_dr_cycles", ns, e.n_shift);
            checkOutput("up_enable_pulses", nu, e.n_up);
            checkOutput("bypass_cycles", nb, e.n_bp);
            checkOutput("busy_in_done", 32'(busy), 32'd0);
            checkOutput("mode_at_done", 32'(mode), 32'(e.mode));
            if (e.chk_upd) checkOutput("target_update_latch", 32'(upd_latch), 32'(e.upd));
`ifdef SCAN_CHECK_EN
            checkOutput("mismatch_at_done", 32'(mismatch), 32'(e.mm));
`endif
          end
          ns = 0; nu = 0; nb = 0;
        end
      end
    end
  end

  initial begin
    // Reset values with the clock running.
    repeat (3) @(negedge tck);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_mode", 32'(mode), 32'd0);
    checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    @(negedge tck);

    // Abort during SHIFT cycle k=3 of an EXTEST (cycle 5 after acceptance).
    applyStimulus(OP_EXTEST, 1'b1, 6'b101100, 6'b010011, 6'b101100, 6'b010011);
    repeat (4) @(negedge tck);
    checkOutput("pre_reset_shift_dr", 32'(shift_dr), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rx_data", 32'(rx_data), 32'd0);
    checkOutput("abort_tdi", 32'(tdi), 32'd0);
    checkOutput("abort_shift_dr", 32'(shift_dr), 32'd0);
    checkOutput("abort_up_enable", 32'(up_enable), 32'd0);
    checkOutput("abort_mode", 32'(mode), 32'd0);
    checkOutput("abort_sel", 32'(sel), 32'd0);
    checkOutput("abort_bp_shift", 32'(bp_shift), 32'd0);
    checkOutput("abort_state", 32'(dut.state_q), 32'(IDLE));
    sb.delete();
    repeat (2) @(negedge tck);
    rst = 1'b0;
    repeat (2) @(negedge tck);
    checkOutput("abort_target_not_updated", 32'(upd_latch), 32'd0);

    // Full EXTEST after the abort.
    applyStimulus(OP_EXTEST, 1'b1, 6'b101100, 6'b010011, 6'b101100, 6'b010011);
    checkOutput("extest_capture_shift_dr", 32'(shift_dr), 32'd0);
    checkOutput("extest_busy", 32'(busy), 32'd1);
    waitDone("extest_done");
    @(negedge tck);
    checkOutput("idle_mode_held", 32'(mode), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_sel", 32'(sel), 32'd0);

    // BYPASS followed back-to-back by an EXTEST in the first IDLE cycle.
    applyStimulus(OP_BYPASS, 1'b0, 6'b110101, 6'b110101, 6'b000000, 6'b110101);
    checkOutput("bypass_sel", 32'(sel), 32'd1);
    waitDone("bypass_done");
    applyStimulus(OP_EXTEST, 1'b1, 6'b011010, 6'b010011, 6'b011010, 6'b010011);
    checkOutput("b2b_rx_held", 32'(rx_data), 32'(6'b110101));
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone("b2b_done");

    // Starts mid-SHIFT and in the DONE cycle must be ignored.
    applyStimulus(OP_EXTEST, 1'b1, 6'b001111, 6'b010011, 6'b001111, 6'b010011);
    repeat (3) @(negedge tck);
    start = 1'b1; op = OP_BYPASS; tx_data = 6'b111000;
    @(negedge tck);
    start = 1'b0;
    waitDone("busy_prot_done");
    start = 1'b1; op = OP_BYPASS; tx_data = 6'b100001;
    @(negedge tck);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("ignored_start_busy", 32'(busy), 32'd0);
      @(negedge tck);
    end
    checkOutput("ignored_start_rx_held", 32'(rx_data), 32'(6'b010011));

`ifdef SCAN_CHECK_EN
    applyStimulus(OP_EXTEST, 1'b1, 6'b101100, 6'b010011, 6'b101100, 6'b010011);
    waitDone("check_match_done");
    applyStimulus(OP_EXTEST, 1'b1, 6'b101100, 6'b010011, 6'b101100, 6'b010010);
    waitDone("check_mismatch_done");
    repeat (2) @(negedge tck);
    checkOutput("mismatch_held", 32'(mismatch), 32'd1);
`endif

    repeat (3) @(negedge tck);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
